// File: rtl/rv32_bus_fabric.sv
// rv32_bus_fabric: routes picorv32 native-bus requests to one of N_TARGETS
// address-decoded targets. Unmapped addresses and targets that never answer
// within TIMEOUT cycles complete with ERR_DATA and are logged in sticky
// error status (flag, last address, saturating count).
module rv32_bus_fabric #(
  parameter int                      N_TARGETS   = 3,
  parameter logic [64*N_TARGETS-1:0] ADDR_RANGES = {32'h00000000, 32'h0000ffff,
                                                    32'hfffffffc, 32'hffffffff,
                                                    32'h00010000, 32'h00020000},
  parameter int                      TIMEOUT     = 255,
  parameter logic [31:0]             ERR_DATA    = 32'hdeadbeef,
  parameter int                      CNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rv32_valid,
  output logic                    rv32_ready,
  input  logic [31:0]             rv32_addr,
  output logic [31:0]             rv32_rdata,
  output logic [N_TARGETS-1:0]    valids,
  input  logic [N_TARGETS-1:0]    readys,
  input  logic [32*N_TARGETS-1:0] rdatas,
  input  logic                    err_clear,
  output logic                    err,
  output logic [31:0]             err_addr,
  output logic [CNT_WIDTH-1:0]    err_count
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RESP
  } state_t;

  state_t                 r_state;
  logic [N_TARGETS-1:0]   r_valids;
  logic                   r_ready;
  logic [31:0]            r_rdata;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic                   r_err;
  logic [31:0]            r_err_addr;
  logic [CNT_WIDTH-1:0]   r_err_count;

  // w_match is indexed by target number; w_sel_onehot and r_valids use the
  // port bit order (target i at bit N_TARGETS-1-i).
  logic [N_TARGETS-1:0]   w_match;
  logic [N_TARGETS-1:0]   w_sel_onehot;
  logic [32*N_TARGETS-1:0] w_rdata_mask;
  logic                   w_hit;
  logic                   w_sel_ready;
  logic [31:0]            w_sel_rdata;
  logic                   w_timeout;
  logic                   w_err_event;

  for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_target
    localparam logic [31:0] LO = ADDR_RANGES[64*(N_TARGETS-1-gi)+63 -: 32];
    localparam logic [31:0] HI = ADDR_RANGES[64*(N_TARGETS-1-gi)+31 -: 32];
    // Targets with a smaller index than gi; any of them matching takes priority.
    localparam logic [N_TARGETS-1:0] LOWER = N_TARGETS'((33'd1 << gi) - 33'd1);

    // Unsigned range test via 33-bit differences: the borrow bit flags "below".
    logic [32:0] w_from_lo;
    logic [32:0] w_to_hi;
    assign w_from_lo = {1'b0, rv32_addr} - {1'b0, LO};
    assign w_to_hi   = {1'b0, HI} - {1'b0, rv32_addr};
    assign w_match[gi] = ~w_from_lo[32] & ~w_to_hi[32];

    assign w_sel_onehot[N_TARGETS-1-gi] = w_match[gi] & ~(|(w_match & LOWER));

    // Per-bit mask used to pick the selected target's read data.
    assign w_rdata_mask[32*gi +: 32] = {32{r_valids[gi]}};
  end

  assign w_hit       = |w_match;
  assign w_sel_ready = |(readys & r_valids);
  assign w_timeout   = TIMEOUT_EN && (r_wait_cnt == WAIT_LAST);

  // AND-OR mux of target read data, steered by the latched one-hot select.
  always_comb begin
    w_sel_rdata = '0;
    for (int j = 0; j < N_TARGETS; j++) begin
      w_sel_rdata = w_sel_rdata | 32'((rdatas & w_rdata_mask) >> (32 * j));
    end
  end

  // Error events: unmapped request in IDLE, or the selected target timing out.
  always_comb begin
    w_err_event = 1'b0;
    if (r_state == S_IDLE) begin
      w_err_event = rv32_valid && !w_hit;
    end else if (r_state == S_ACTIVE) begin
      w_err_event = w_timeout && !w_sel_ready;
    end
  end

  // Request FSM with registered target strobes, host ready and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valids   <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (rv32_valid) begin
            if (w_hit) begin
              r_valids   <= w_sel_onehot;
              r_wait_cnt <= '0;
              r_state    <= S_ACTIVE;
            end else begin
              r_rdata <= ERR_DATA;
              r_ready <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_ACTIVE: begin
          // A ready in the threshold cycle still counts as normal completion.
          if (w_sel_ready) begin
            r_rdata  <= w_sel_rdata;
            r_valids <= '0;
            r_ready  <= 1'b1;
            r_state  <= S_RESP;
          end else if (w_timeout) begin
            r_rdata  <= ERR_DATA;
            r_valids <= '0;
            r_ready  <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valids <= '0;
          r_ready  <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error status; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else if (w_err_event) begin
      r_err      <= 1'b1;
      r_err_addr <= rv32_addr;
      if (err_clear) begin
        r_err_count <= CNT_WIDTH'(1);
      end else if (r_err_count != {CNT_WIDTH{1'b1}}) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end else if (err_clear) begin
      r_err       <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end
  end

  assign valids     = r_valids;
  assign rv32_ready = r_ready;
  assign rv32_rdata = r_rdata;
  assign err        = r_err;
  assign err_addr   = r_err_addr;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_rv32_bus_fabric.sv
// tb_rv32_bus_fabric: random and directed accesses against a queue-based
// scoreboard. The issuing task computes each expected response from the
// address map and the target's response delay; a negedge monitor pops and
// compares whenever the fabric pulses rv32_ready.
module tb_rv32_bus_fabric;

  localparam int          NT   = 3;
  localparam int          TO   = 4;
  localparam int          CW   = 2;
  localparam logic [31:0] ERRD = 32'hdeadbeef;
  // Target 2 deliberately overlaps the top of target 0 (0xf000..0xffff).
  localparam logic [64*NT-1:0] RANGES = {32'h00000000, 32'h0000ffff,
                                         32'hfffffffc, 32'hffffffff,
                                         32'h0000f000, 32'h00020000};
  localparam logic [31:0] LO_TAB [NT] = '{32'h00000000, 32'hfffffffc, 32'h0000f000};
  localparam logic [31:0] HI_TAB [NT] = '{32'h0000ffff, 32'hffffffff, 32'h00020000};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rv32_valid = 1'b0;
  logic             rv32_ready;
  logic [31:0]      rv32_addr = '0;
  logic [31:0]      rv32_rdata;
  logic [NT-1:0]    valids;
  logic [NT-1:0]    readys = '0;
  logic [32*NT-1:0] rdatas = '0;
  logic             err_clear = 1'b0;
  logic             err;
  logic [31:0]      err_addr;
  logic [CW-1:0]    err_count;

  rv32_bus_fabric #(
    .N_TARGETS  (NT),
    .ADDR_RANGES(RANGES),
    .TIMEOUT    (TO),
    .ERR_DATA   (ERRD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rv32_valid(rv32_valid),
    .rv32_ready(rv32_ready),
    .rv32_addr (rv32_addr),
    .rv32_rdata(rv32_rdata),
    .valids    (valids),
    .readys    (readys),
    .rdatas    (rdatas),
    .err_clear (err_clear),
    .err       (err),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          lat;
    logic [2:0]  onehot;
    int          vcyc;
    logic        err;
    logic [31:0] eaddr;
    logic [1:0]  ecnt;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn = 0;

  // Reference model of the error status and of the held read data.
  logic        m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_cnt = '0;
  logic [31:0] m_hold = '0;

  int          cur_k = 255;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NT; i++) begin
      if (a >= LO_TAB[i] && a <= HI_TAB[i]) return i;
    end
    return -1;
  endfunction

  // Target emulation: the selected target answers cur_k cycles after its
  // strobe rises; unselected ready lines carry random noise.
  int act_cnt = 0;
  always @(negedge clk) begin
    logic [NT-1:0] junk;
    junk = NT'($urandom);
    if (valids != '0) begin
      readys = (junk & ~valids) | ((act_cnt == cur_k) ? valids : '0);
      act_cnt++;
    end else begin
      readys = junk;
      act_cnt = 0;
    end
  end

  // Monitor: accumulate the strobe pattern, compare on every ready pulse.
  logic [NT-1:0] obs_or = '0;
  int            obs_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      obs_or  = '0;
      obs_cnt = 0;
    end else begin
      if (valids != '0) begin
        obs_or = obs_or | valids;
        obs_cnt++;
      end
      if (rv32_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready: got rv32_ready=1, expected no pending request");
        end else begin
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d addr=%h rdata=%h lat=%0d valids_seen=%b err=%b err_count=%0d",
                   n_txn, e.addr, rv32_rdata, cyc - e.issue, obs_or, err, err_count);
          chk("rdata", rv32_rdata, e.rdata);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("valids_pattern", 32'(obs_or), 32'(e.onehot));
          chk("valids_cycles", 32'(obs_cnt), 32'(e.vcyc));
          chk("err", 32'(err), 32'(e.err));
          chk("err_addr", err_addr, e.eaddr);
          chk("err_count", 32'(err_count), 32'(e.ecnt));
          m_hold = e.rdata;
        end
        obs_or  = '0;
        obs_cnt = 0;
      end else begin
        chk("rdata_hold", rv32_rdata, m_hold);
      end
    end
  end

  // Issue one host access, push its expected response, wait for completion.
  task automatic do_access(input logic [31:0] addr, input int k, input logic clr, input int gap);
    exp_t        e;
    int          t;
    int          n;
    logic [31:0] d [NT];
    for (int i = 0; i < NT; i++) d[i] = $urandom;
    rdatas = {d[0], d[1], d[2]};
    cur_k  = k;

    t = decode(addr);
    e.addr   = addr;
    e.onehot = '0;
    if (t < 0) begin
      e.rdata = ERRD; e.lat = 1; e.vcyc = 0;
    end else begin
      e.onehot = 3'b100 >> t;
      if (k < TO) begin
        e.rdata = d[t]; e.lat = k + 2; e.vcyc = k + 1;
      end else begin
        e.rdata = ERRD; e.lat = TO + 1; e.vcyc = TO;
      end
    end
    if (clr) begin
      m_err = 1'b0; m_addr = '0; m_cnt = '0;
    end
    if (t < 0 || k >= TO) begin
      m_err = 1'b1; m_addr = addr;
      if (m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
    end
    e.err   = m_err;
    e.eaddr = m_addr;
    e.ecnt  = m_cnt;
    e.issue = cyc;
    sb.push_back(e);

    rv32_valid = 1'b1;
    rv32_addr  = addr;
    err_clear  = clr;
    @(negedge clk);
    err_clear = 1'b0;
    n = 0;
    while (!rv32_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rv32_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_wait: no rv32_ready within 40 cycles for addr %h", addr);
      sb.delete();
    end
    @(negedge clk);
    if (gap > 0) begin
      rv32_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'($urandom_range(32'h0000efff, 0));
      1: return ($urandom_range(0, 1) == 0) ? 32'h00000000 : 32'h0000ffff;
      2: return 32'hfffffffc + 32'($urandom_range(0, 3));
      3: return 32'($urandom_range(32'h00020000, 32'h00010000));
      4: return 32'($urandom_range(32'h0000ffff, 32'h0000f000));
      5: return 32'($urandom_range(32'hfffffffb, 32'h00020001));
      6: begin
        case ($urandom_range(0, 3))
          0:       return 32'h00020000;
          1:       return 32'h00020001;
          2:       return 32'hfffffffb;
          default: return 32'h0000f000;
        endcase
      end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valids", 32'(valids), 32'h0);
    chk("reset_ready", 32'(rv32_ready), 32'h0);
    chk("reset_rdata", rv32_rdata, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);
    chk("reset_err_count", 32'(err_count), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_access(32'h00000010, 2, 1'b0, 0);
    do_access(32'h00030000, 0, 1'b0, 1);
    do_access(32'h00010004, 255, 1'b0, 0);
    do_access(32'h00010004, 3, 1'b0, 1);
    repeat (5) do_access(32'h00030000, 0, 1'b0, 0);
    do_access(32'h00030004, 0, 1'b1, 0);
    do_access(32'h0000f800, 1, 1'b0, 0);
    rv32_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of an ACTIVE access.
    cur_k      = 255;
    rv32_addr  = 32'h00000010;
    rv32_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_active_valids", 32'(valids), 32'h4);
    reset = 1'b1; rv32_valid = 1'b0;
    m_hold = '0; m_err = 1'b0; m_addr = '0; m_cnt = '0;
    sb.delete();
    #1;
    chk("rst_mid_valids", 32'(valids), 32'h0);
    chk("rst_mid_ready", 32'(rv32_ready), 32'h0);
    chk("rst_mid_rdata", rv32_rdata, 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    chk("rst_mid_err_addr", err_addr, 32'h0);
    chk("rst_mid_err_count", 32'(err_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_access(32'hfffffffc, 0, 1'b0, 1);

    for (int i = 0; i < 60; i++) begin
      do_access(rand_addr(), int'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end
    rv32_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("leftover_expected", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_bus_fabric.md
RV32_BUS_FABRIC -- requirements
Module: rv32_bus_fabric

Interface
REQ-001 SHALL have parameter N_TARGETS, default 3: number of bus targets (1..16).
REQ-002 SHALL have parameter ADDR_RANGES, default {32'h00000000,32'h0000ffff, 32'hfffffffc,32'hffffffff, 32'h00010000,32'h00020000}, width 64*N_TARGETS: target i range at bits [64*(N_TARGETS-1-i)+63 -: 32]=lo, [64*(N_TARGETS-1-i)+31 -: 32]=hi, inclusive.
REQ-003 SHALL have parameter TIMEOUT, default 255: max cycles waiting for target ready; 0 disables timeout.
REQ-004 SHALL have parameter ERR_DATA, default 32'hdeadbeef: rdata returned on error.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: error counter width.
REQ-006 Ports (one clock; reset is asynchronous and active-high):
 clk  in  1  system clock, all logic on rising edge
 reset  in  1  asynchronous active-high reset
 rv32_valid  in  1  host request (picorv32 native)
 rv32_ready  out  1  host completion pulse
 rv32_addr  in  32  host address
 rv32_rdata  out  32  host read data
 valids  out  N_TARGETS  per-target request, one-hot or zero; bit N_TARGETS-1-i = target i
 readys  in  N_TARGETS  per-target completion, same bit order
 rdatas  in  32*N_TARGETS  per-target read data, same order as ADDR_RANGES
 err_clear  in  1  clears err, err_addr, err_count
 err  out  1  sticky error flag
 err_addr  out  32  address of most recent error
 err_count  out  CNT_WIDTH  saturating error count
REQ-007 wdata/wstrb SHALL NOT pass through this block; targets take them from the host directly.

Function
REQ-008 States: IDLE, ACTIVE, RESP.
REQ-009 Decode: target i matches when lo_i <= rv32_addr <= hi_i (unsigned); on overlap lowest i wins.
REQ-010 IDLE, rv32_valid=1, match: latch sel=i, clear wait counter, go ACTIVE.
REQ-011 IDLE, rv32_valid=1, no match: go RESP with rdata=ERR_DATA, record error (REQ-016).
REQ-012 ACTIVE: valids has only bit sel asserted; all other states valids=0.
REQ-013 ACTIVE, readys[sel]=1: capture rdatas[sel] into rdata register, go RESP; readys of other targets ignored.
REQ-014 ACTIVE, TIMEOUT!=0, no readys[sel], wait counter==TIMEOUT-1: go RESP with ERR_DATA, record error; else counter increments. readys[sel] in the threshold cycle wins (normal completion).
REQ-015 RESP: rv32_ready=1 for exactly one cycle, rv32_rdata=registered value; next state IDLE unconditionally. rv32_rdata holds its value outside RESP.
REQ-016 Recording error: err<=1, err_addr<=rv32_addr, err_count<=err_count+1, saturating at all-ones.
REQ-017 err_clear alone: err<=0, err_addr<=0, err_count<=0. err_clear with same-cycle error: error wins; err=1, err_addr=new address, err_count=1.
REQ-018 Latency: mapped access, target ready k cycles after valids rises (k>=0) -> rv32_ready k+2 cycles after IDLE samples rv32_valid; unmapped -> 1 cycle.
REQ-019 Host contract: rv32_valid held stable until rv32_ready, dropped in the cycle after; fabric samples a new request only in IDLE.

Reset
REQ-020 reset=1 SHALL immediately force IDLE, valids=0, rv32_ready=0, rv32_rdata=0, err=0, err_addr=0, err_count=0, wait counter=0, including mid-ACTIVE/RESP.
REQ-021 After reset deasserts, the first rising edge with rv32_valid=1 SHALL be treated as a new request.

Verification
REQ-022 Read addr 32'h00000010, target0 ready 2 cycles later with rdata 32'h12345678 -> valids=3'b100 for 3 cycles, rv32_ready pulse 4 cycles after request, rv32_rdata=32'h12345678, err=0.
REQ-023 Read addr 32'h00030000 (unmapped) -> no valids, rv32_ready next cycle, rdata=32'hdeadbeef, err=1, err_addr=32'h00030000, err_count=1.
REQ-024 Addr 32'h00010004, target2 never ready, TIMEOUT=4 -> valids=3'b001 for 4 cycles, then rv32_ready with 32'hdeadbeef, err_count+1; TIMEOUT=4 with ready in 4th cycle -> normal data, no error.
REQ-025 CNT_WIDTH=2, five unmapped accesses -> err_count=2'b11; err_clear in same cycle as sixth error -> err_count=1, err=1.
REQ-026 reset asserted mid-ACTIVE -> valids=0, rv32_ready=0, all status 0 in the same cycle; subsequent access to 32'hfffffffc completes normally via target1 (valids=3'b010).
REQ-027 Overlapping ranges (target0 and target1 both cover addr) -> only target0 selected.
